// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register with operand forwarding.
// Captures the decoded instruction on each clock edge (unless stalled or
// flushed) and presents ALU operands, resolving data hazards against the
// MEM and WB stages combinationally from the registered source indices.
module ex_operand_stage #(
  parameter int DATA_WIDTH     = 32,
  parameter int OPCODE_LENGTH  = 4,
  parameter int REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      id_valid,
  input  logic [DATA_WIDTH-1:0]     id_rs1_data,
  input  logic [DATA_WIDTH-1:0]     id_rs2_data,
  input  logic [DATA_WIDTH-1:0]     id_imm,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs1_addr,
  input  logic [REG_ADDR_WIDTH-1:0] id_rs2_addr,
  input  logic [REG_ADDR_WIDTH-1:0] id_rd_addr,
  input  logic [OPCODE_LENGTH-1:0]  id_alu_op,
  input  logic                      id_alu_src,
  input  logic                      id_reg_write,
  input  logic                      stall,
  input  logic                      flush,
  input  logic                      mem_reg_write,
  input  logic [REG_ADDR_WIDTH-1:0] mem_rd_addr,
  input  logic [DATA_WIDTH-1:0]     mem_result,
  input  logic                      wb_reg_write,
  input  logic [REG_ADDR_WIDTH-1:0] wb_rd_addr,
  input  logic [DATA_WIDTH-1:0]     wb_result,
  output logic [DATA_WIDTH-1:0]     SrcA,
  output logic [DATA_WIDTH-1:0]     SrcB,
  output logic [OPCODE_LENGTH-1:0]  Operation,
  output logic                      ex_valid,
  output logic                      ex_reg_write,
  output logic [REG_ADDR_WIDTH-1:0] ex_rd_addr,
  output logic [DATA_WIDTH-1:0]     ex_store_data
);

  logic                      valid_q;
  logic [DATA_WIDTH-1:0]     rs1_data_q;
  logic [DATA_WIDTH-1:0]     rs2_data_q;
  logic [DATA_WIDTH-1:0]     imm_q;
  logic [REG_ADDR_WIDTH-1:0] rs1_addr_q;
  logic [REG_ADDR_WIDTH-1:0] rs2_addr_q;
  logic [REG_ADDR_WIDTH-1:0] rd_addr_q;
  logic [OPCODE_LENGTH-1:0]  alu_op_q;
  logic                      alu_src_q;
  logic                      reg_write_q;

  logic [DATA_WIDTH-1:0]     fwd_rs1;
  logic [DATA_WIDTH-1:0]     fwd_rs2;

  // ID/EX register: reset clears everything, flush kills the slot even while
  // stalled, stall freezes it, otherwise the decoded instruction is captured.
  // Write-enable is qualified by valid so a bubble can never write back.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q     <= 1'b0;
      rs1_data_q  <= '0;
      rs2_data_q  <= '0;
      imm_q       <= '0;
      rs1_addr_q  <= '0;
      rs2_addr_q  <= '0;
      rd_addr_q   <= '0;
      alu_op_q    <= '0;
      alu_src_q   <= 1'b0;
      reg_write_q <= 1'b0;
    end else if (flush) begin
      valid_q     <= 1'b0;
      reg_write_q <= 1'b0;
    end else if (!stall) begin
      valid_q     <= id_valid;
      rs1_data_q  <= id_rs1_data;
      rs2_data_q  <= id_rs2_data;
      imm_q       <= id_imm;
      rs1_addr_q  <= id_rs1_addr;
      rs2_addr_q  <= id_rs2_addr;
      rd_addr_q   <= id_rd_addr;
      alu_op_q    <= id_alu_op;
      alu_src_q   <= id_alu_src;
      reg_write_q <= id_reg_write & id_valid;
    end
  end

  // Forwarding: the younger MEM result wins over WB; register 0 is hardwired
  // so it is never forwarded. Evaluated every cycle, including while stalled.
  always_comb begin
    fwd_rs1 = rs1_data_q;
    if (mem_reg_write && (mem_rd_addr == rs1_addr_q) && (rs1_addr_q != '0))
      fwd_rs1 = mem_result;
    else if (wb_reg_write && (wb_rd_addr == rs1_addr_q) && (rs1_addr_q != '0))
      fwd_rs1 = wb_result;

    fwd_rs2 = rs2_data_q;
    if (mem_reg_write && (mem_rd_addr == rs2_addr_q) && (rs2_addr_q != '0))
      fwd_rs2 = mem_result;
    else if (wb_reg_write && (wb_rd_addr == rs2_addr_q) && (rs2_addr_q != '0))
      fwd_rs2 = wb_result;
  end

  // Output mux: immediate replaces rs2 for SrcB, store data always takes the
  // forwarded rs2, and an invalid slot presents the benign AND opcode.
  always_comb begin
    SrcA          = fwd_rs1;
    SrcB          = alu_src_q ? imm_q : fwd_rs2;
    ex_store_data = fwd_rs2;
    Operation     = valid_q ? alu_op_q : '0;
    ex_valid      = valid_q;
    ex_reg_write  = reg_write_q;
    ex_rd_addr    = rd_addr_q;
  end

endmodule

// File: tb/tb_ex_operand_stage.sv
// Directed bench for ex_operand_stage: a table of single-instruction
// vectors followed by hand-written stall/flush/reset sequences.
module tb_ex_operand_stage;

  logic        clk;
  logic        reset;
  logic        idValid;
  logic [31:0] idRs1Data;
  logic [31:0] idRs2Data;
  logic [31:0] idImm;
  logic [4:0]  idRs1Addr;
  logic [4:0]  idRs2Addr;
  logic [4:0]  idRdAddr;
  logic [3:0]  idAluOp;
  logic        idAluSrc;
  logic        idRegWrite;
  logic        stall;
  logic        flush;
  logic        memRegWrite;
  logic [4:0]  memRdAddr;
  logic [31:0] memResult;
  logic        wbRegWrite;
  logic [4:0]  wbRdAddr;
  logic [31:0] wbResult;
  logic [31:0] srcA;
  logic [31:0] srcB;
  logic [3:0]  operation;
  logic        exValid;
  logic        exRegWrite;
  logic [4:0]  exRdAddr;
  logic [31:0] exStoreData;

  int checks;
  int failures;

  typedef struct {
    logic        idValid;
    logic [4:0]  rs1Addr;
    logic [31:0] rs1Data;
    logic [4:0]  rs2Addr;
    logic [31:0] rs2Data;
    logic [31:0] imm;
    logic [4:0]  rdAddr;
    logic [3:0]  aluOp;
    logic        aluSrc;
    logic        regWrite;
    logic        memRw;
    logic [4:0]  memRd;
    logic [31:0] memRes;
    logic        wbRw;
    logic [4:0]  wbRd;
    logic [31:0] wbRes;
    logic [31:0] expA;
    logic [31:0] expB;
    logic [31:0] expStore;
    logic [3:0]  expOp;
    logic        expValid;
    logic        expRw;
    logic [4:0]  expRd;
  } vec_t;

  vec_t vecs[7];

  ex_operand_stage dut (
    .clk           (clk),
    .reset         (reset),
    .id_valid      (idValid),
    .id_rs1_data   (idRs1Data),
    .id_rs2_data   (idRs2Data),
    .id_imm        (idImm),
    .id_rs1_addr   (idRs1Addr),
    .id_rs2_addr   (idRs2Addr),
    .id_rd_addr    (idRdAddr),
    .id_alu_op     (idAluOp),
    .id_alu_src    (idAluSrc),
    .id_reg_write  (idRegWrite),
    .stall         (stall),
    .flush         (flush),
    .mem_reg_write (memRegWrite),
    .mem_rd_addr   (memRdAddr),
    .mem_result    (memResult),
    .wb_reg_write  (wbRegWrite),
    .wb_rd_addr    (wbRdAddr),
    .wb_result     (wbResult),
    .SrcA          (srcA),
    .SrcB          (srcB),
    .Operation     (operation),
    .ex_valid      (exValid),
    .ex_reg_write  (exRegWrite),
    .ex_rd_addr    (exRdAddr),
    .ex_store_data (exStoreData)
  );

  // Free-running 10-unit clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    idValid     = v.idValid;
    idRs1Addr   = v.rs1Addr;
    idRs1Data   = v.rs1Data;
    idRs2Addr   = v.rs2Addr;
    idRs2Data   = v.rs2Data;
    idImm       = v.imm;
    idRdAddr    = v.rdAddr;
    idAluOp     = v.aluOp;
    idAluSrc    = v.aluSrc;
    idRegWrite  = v.regWrite;
    memRegWrite = v.memRw;
    memRdAddr   = v.memRd;
    memResult   = v.memRes;
    wbRegWrite  = v.wbRw;
    wbRdAddr    = v.wbRd;
    wbResult    = v.wbRes;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, " SrcA"}, srcA, 32'h0);
    checkOutput({tag, " SrcB"}, srcB, 32'h0);
    checkOutput({tag, " store"}, exStoreData, 32'h0);
    checkOutput({tag, " Operation"}, 32'(operation), 32'h0);
    checkOutput({tag, " ex_valid"}, 32'(exValid), 32'h0);
    checkOutput({tag, " ex_reg_write"}, 32'(exRegWrite), 32'h0);
    checkOutput({tag, " ex_rd_addr"}, 32'(exRdAddr), 32'h0);
  endtask

  initial begin
    checks   = 0;
    failures = 0;

    vecs[0] = '{1'b1, 5'd1, 32'h5, 5'd2, 32'h7, 32'h0, 5'd3, 4'h2, 1'b0, 1'b1,
                1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                32'h5, 32'h7, 32'h7, 4'h2, 1'b1, 1'b1, 5'd3};
    vecs[1] = '{1'b1, 5'd3, 32'h55, 5'd6, 32'h66, 32'h0, 5'd7, 4'h1, 1'b0, 1'b1,
                1'b1, 5'd3, 32'h11, 1'b1, 5'd3, 32'h22,
                32'h11, 32'h66, 32'h66, 4'h1, 1'b1, 1'b1, 5'd7};
    vecs[2] = '{1'b1, 5'd3, 32'h55, 5'd6, 32'h66, 32'h0, 5'd7, 4'h1, 1'b0, 1'b1,
                1'b0, 5'd3, 32'h11, 1'b1, 5'd3, 32'h22,
                32'h22, 32'h66, 32'h66, 4'h1, 1'b1, 1'b1, 5'd7};
    vecs[3] = '{1'b1, 5'd0, 32'h0, 5'd0, 32'h3, 32'h0, 5'd2, 4'h3, 1'b0, 1'b1,
                1'b1, 5'd0, 32'hFF, 1'b1, 5'd0, 32'hEE,
                32'h0, 32'h3, 32'h3, 4'h3, 1'b1, 1'b1, 5'd2};
    vecs[4] = '{1'b1, 5'd5, 32'h5, 5'd4, 32'h44, 32'h10, 5'd9, 4'h6, 1'b1, 1'b1,
                1'b1, 5'd4, 32'h99, 1'b0, 5'd0, 32'h0,
                32'h5, 32'h10, 32'h99, 4'h6, 1'b1, 1'b1, 5'd9};
    vecs[5] = '{1'b0, 5'd8, 32'h80, 5'd9, 32'h90, 32'h0, 5'd12, 4'h5, 1'b0, 1'b1,
                1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0,
                32'h80, 32'h90, 32'h90, 4'h0, 1'b0, 1'b0, 5'd12};
    vecs[6] = '{1'b1, 5'd1, 32'h1, 5'd10, 32'hA0, 32'h0, 5'd15, 4'hF, 1'b0, 1'b0,
                1'b0, 5'd10, 32'h77, 1'b1, 5'd10, 32'hAB,
                32'h1, 32'hAB, 32'hAB, 4'hF, 1'b1, 1'b0, 5'd15};

    // Reset with a live instruction pending; no forwarding sources active
    reset = 1'b1;
    stall = 1'b0;
    flush = 1'b0;
    applyStimulus(vecs[0]);
    memRegWrite = 1'b0;
    wbRegWrite  = 1'b0;
    tick();
    checkAllZero("reset");
    reset = 1'b0;

    // Table-driven single-instruction vectors
    for (int i = 0; i < 7; i++) begin
      applyStimulus(vecs[i]);
      tick();
      checkOutput($sformatf("v%0d SrcA", i), srcA, vecs[i].expA);
      checkOutput($sformatf("v%0d SrcB", i), srcB, vecs[i].expB);
      checkOutput($sformatf("v%0d store", i), exStoreData, vecs[i].expStore);
      checkOutput($sformatf("v%0d Operation", i), 32'(operation), 32'(vecs[i].expOp));
      checkOutput($sformatf("v%0d ex_valid", i), 32'(exValid), 32'(vecs[i].expValid));
      checkOutput($sformatf("v%0d ex_reg_write", i), 32'(exRegWrite), 32'(vecs[i].expRw));
      checkOutput($sformatf("v%0d ex_rd_addr", i), 32'(exRdAddr), 32'(vecs[i].expRd));
    end

    // Stall holds v6 while new decode data is presented
    memRegWrite = 1'b0;
    wbRegWrite  = 1'b0;
    stall       = 1'b1;
    idValid     = 1'b1;
    idRs1Addr   = 5'd2;
    idRs1Data   = 32'h123;
    idRs2Addr   = 5'd3;
    idRs2Data   = 32'h456;
    idAluOp     = 4'h7;
    idRdAddr    = 5'd20;
    idRegWrite  = 1'b1;
    tick();
    checkOutput("stall SrcA", srcA, 32'h1);
    checkOutput("stall SrcB", srcB, 32'hA0);
    checkOutput("stall Operation", 32'(operation), 32'hF);
    checkOutput("stall ex_rd_addr", 32'(exRdAddr), 32'd15);
    checkOutput("stall ex_reg_write", 32'(exRegWrite), 32'h0);

    // Forwarding keeps tracking MEM while stalled
    memRegWrite = 1'b1;
    memRdAddr   = 5'd1;
    memResult   = 32'h5A;
    #1;
    checkOutput("stall fwd SrcA", srcA, 32'h5A);

    // Flush wins over stall on the same edge
    flush = 1'b1;
    tick();
    checkOutput("flush ex_valid", 32'(exValid), 32'h0);
    checkOutput("flush ex_reg_write", 32'(exRegWrite), 32'h0);
    checkOutput("flush Operation", 32'(operation), 32'h0);
    flush = 1'b0;
    stall = 1'b0;

    // Reset arriving mid-stall
    memRegWrite = 1'b0;
    wbRegWrite  = 1'b0;
    idValid     = 1'b1;
    idRs1Addr   = 5'd7;
    idRs1Data   = 32'h70;
    idRs2Addr   = 5'd8;
    idRs2Data   = 32'h80;
    idImm       = 32'h0;
    idAluSrc    = 1'b0;
    idAluOp     = 4'h2;
    idRdAddr    = 5'd4;
    idRegWrite  = 1'b1;
    tick();
    checkOutput("preload ex_valid", 32'(exValid), 32'h1);
    checkOutput("preload ex_reg_write", 32'(exRegWrite), 32'h1);
    stall = 1'b1;
    reset = 1'b1;
    tick();
    checkAllZero("reset mid-stall");

    // Normal load after reset release
    reset     = 1'b0;
    stall     = 1'b0;
    idRs1Addr = 5'd3;
    idRs1Data = 32'h31;
    idAluOp   = 4'h4;
    idRdAddr  = 5'd6;
    tick();
    checkOutput("post-reset SrcA", srcA, 32'h31);
    checkOutput("post-reset SrcB", srcB, 32'h80);
    checkOutput("post-reset Operation", 32'(operation), 32'h4);
    checkOutput("post-reset ex_valid", 32'(exValid), 32'h1);
    checkOutput("post-reset ex_rd_addr", 32'(exRdAddr), 32'd6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
